// File: rtl/sd_pkg.sv
// sd_pkg
//  Shared definitions for the SD command arbiter slice: command indices,
//  the completion error code, the arbiter FSM state encoding and a helper
//  for the SDSC byte-address range check.
package sd_pkg;

   localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
   localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;

   // R1 value reported when no command reached the card
   localparam logic [7:0] R1_NONE = 8'hFF;

   typedef enum logic [1:0] {
      OK      = 2'd0,
      R1_ERR  = 2'd1,
      TIMEOUT = 2'd2,
      RANGE   = 2'd3
   } sd_err_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_CHECK = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_ACK   = 3'd5
   } arb_state_t;

   // SDSC cards take a byte address: sector << 9 must fit in 32 bits,
   // so any sector at or above 2^23 cannot be addressed.
   function automatic logic sdsc_out_of_range(input logic [31:0] sector);
      return |sector[31:23];
   endfunction

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// sd_cmd_arbiter_if
//  Bundles the requester side and the engine side of the SD command arbiter.
//  Ports (per signal):
//   req/req_write/req_sector  requester -> arbiter, level request + block info
//   grant/ack/rsp_r1/rsp_err  arbiter -> requester, grant window + completion
//   card_ready/card_ccs       engine -> arbiter, card status
//   eng_start/eng_cmd_idx/eng_arg  arbiter -> engine, command launch
//   eng_busy/eng_done/eng_r1  engine -> arbiter, command progress + R1
//  Modports: slave = arbiter view, master = requesters/engine view.
interface sd_cmd_arbiter_if #(
   parameter int NUM_REQ = 3
);
   import sd_pkg::*;

   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ*32-1:0] req_sector;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    ack;
   logic [7:0]            rsp_r1;
   sd_err_t               rsp_err;
   logic                  card_ready;
   logic                  card_ccs;
   logic                  eng_start;
   logic [5:0]            eng_cmd_idx;
   logic [31:0]           eng_arg;
   logic                  eng_busy;
   logic                  eng_done;
   logic [7:0]            eng_r1;

   modport slave (
      input  req, req_write, req_sector, card_ready, card_ccs,
             eng_busy, eng_done, eng_r1,
      output grant, ack, rsp_r1, rsp_err, eng_start, eng_cmd_idx, eng_arg
   );

   modport master (
      output req, req_write, req_sector, card_ready, card_ccs,
             eng_busy, eng_done, eng_r1,
      input  grant, ack, rsp_r1, rsp_err, eng_start, eng_cmd_idx, eng_arg
   );

endinterface

// File: rtl/rr_pick.sv
// rr_pick
//  Combinational round-robin picker: returns the first set request at or
//  after ptr, wrapping at N-1 -> 0.
//  Ports:
//   req    in  N    request vector
//   ptr    in  PW   highest-priority index (must be < N)
//   onehot out N    one-hot of the chosen request (0 when none)
//   idx    out PW   index of the chosen request
//   valid  out 1    some request was set
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx,
   output logic          valid
);

   // pos[k] = (ptr + k) mod N, i.e. the candidate examined at priority k
   logic [PW-1:0] pos [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pos
         logic [PW:0] sum;
         assign sum     = {1'b0, ptr} + (PW+1)'(gi);
         assign pos[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
      end
   endgenerate

   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         if (!valid && req[pos[k]]) begin
            valid = 1'b1;
            idx   = pos[k];
         end
      end
      onehot = valid ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter
//  Shares one SD SPI command engine between NUM_REQ block requesters with
//  round-robin arbitration, one transaction in flight. Chooses CMD17/CMD24,
//  converts the sector to a byte address for SDSC cards, range-checks it,
//  and guards every engine command with a watchdog.
//  Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    sd_cmd_arbiter_if.slave: requester handshake + engine handshake
//  Parameters:
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT_CYC  cycles from eng_start to eng_done before the command is abandoned
module sd_cmd_arbiter
   import sd_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 2000000
) (
   input logic              clk,
   input logic              rst_n,
   sd_cmd_arbiter_if.slave  bus
);

   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W = $clog2(TIMEOUT_CYC);

   arb_state_t          state_reg;
   logic [NUM_REQ-1:0]  grant_reg;
   logic [NUM_REQ-1:0]  ack_reg;
   logic [PW-1:0]       rr_ptr_reg;
   logic [PW-1:0]       gidx_reg;
   logic [31:0]         sector_reg;
   logic                write_reg;
   logic [7:0]          rsp_r1_reg;
   sd_err_t             rsp_err_reg;
   logic                eng_start_reg;
   logic [5:0]          eng_cmd_idx_reg;
   logic [31:0]         eng_arg_reg;
   logic [WD_W-1:0]     wd_reg;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [PW-1:0]       pick_idx;
   logic                pick_valid;
   logic [PW-1:0]       rr_ptr_next;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_pick (
      .req    (bus.req),
      .ptr    (rr_ptr_reg),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign rr_ptr_next = (gidx_reg == PW'(NUM_REQ-1)) ? '0 : gidx_reg + PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         grant_reg       <= '0;
         ack_reg         <= '0;
         rr_ptr_reg      <= '0;
         gidx_reg        <= '0;
         sector_reg      <= '0;
         write_reg       <= 1'b0;
         rsp_r1_reg      <= R1_NONE;
         rsp_err_reg     <= OK;
         eng_start_reg   <= 1'b0;
         eng_cmd_idx_reg <= '0;
         eng_arg_reg     <= '0;
         wd_reg          <= '0;
      end else begin
         eng_start_reg <= 1'b0;
         ack_reg       <= '0;

         // Card lost mid-transaction: finish the granted requester with a timeout
         // code rather than leaving it hanging on a command that cannot complete.
         if (!bus.card_ready &&
             (state_reg == ST_CHECK || state_reg == ST_ISSUE || state_reg == ST_WAIT)) begin
            rsp_err_reg <= TIMEOUT;
            rsp_r1_reg  <= R1_NONE;
            ack_reg     <= grant_reg;
            state_reg   <= ST_ACK;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (bus.card_ready && |bus.req) state_reg <= ST_ARB;
               end

               ST_ARB: begin
                  if (pick_valid) begin
                     grant_reg  <= pick_onehot;
                     gidx_reg   <= pick_idx;
                     sector_reg <= bus.req_sector[32*int'(pick_idx) +: 32];
                     write_reg  <= bus.req_write[pick_idx];
                     if (!bus.card_ready) begin
                        rsp_err_reg <= TIMEOUT;
                        rsp_r1_reg  <= R1_NONE;
                        ack_reg     <= pick_onehot;
                        state_reg   <= ST_ACK;
                     end else begin
                        state_reg <= ST_CHECK;
                     end
                  end else begin
                     // request withdrawn between IDLE and ARB
                     state_reg <= ST_IDLE;
                  end
               end

               ST_CHECK: begin
                  if (!bus.card_ccs && sdsc_out_of_range(sector_reg)) begin
                     rsp_err_reg <= RANGE;
                     rsp_r1_reg  <= R1_NONE;
                     ack_reg     <= grant_reg;
                     state_reg   <= ST_ACK;
                  end else begin
                     // range check above guarantees the shift loses no set bits
                     eng_arg_reg     <= bus.card_ccs ? sector_reg : {sector_reg[22:0], 9'd0};
                     eng_cmd_idx_reg <= write_reg ? CMD_WRITE_SINGLE : CMD_READ_SINGLE;
                     // launch straight away when the engine is free so that
                     // req-to-eng_start stays at three cycles
                     if (!bus.eng_busy) begin
                        eng_start_reg <= 1'b1;
                        wd_reg        <= '0;
                        state_reg     <= ST_WAIT;
                     end else begin
                        state_reg <= ST_ISSUE;
                     end
                  end
               end

               ST_ISSUE: begin
                  if (!bus.eng_busy) begin
                     eng_start_reg <= 1'b1;
                     wd_reg        <= '0;
                     state_reg     <= ST_WAIT;
                  end
               end

               ST_WAIT: begin
                  if (bus.eng_done) begin
                     rsp_r1_reg  <= bus.eng_r1;
                     rsp_err_reg <= (bus.eng_r1 != 8'h00) ? R1_ERR : OK;
                     ack_reg     <= grant_reg;
                     state_reg   <= ST_ACK;
                  end else if (wd_reg == WD_W'(TIMEOUT_CYC-1)) begin
                     rsp_err_reg <= TIMEOUT;
                     rsp_r1_reg  <= R1_NONE;
                     ack_reg     <= grant_reg;
                     state_reg   <= ST_ACK;
                  end else begin
                     wd_reg <= wd_reg + WD_W'(1);
                  end
               end

               ST_ACK: begin
                  grant_reg  <= '0;
                  rr_ptr_reg <= rr_ptr_next;
                  state_reg  <= ST_IDLE;
               end

               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.grant       = grant_reg;
   assign bus.ack         = ack_reg;
   assign bus.rsp_r1      = rsp_r1_reg;
   assign bus.rsp_err     = rsp_err_reg;
   assign bus.eng_start   = eng_start_reg;
   assign bus.eng_cmd_idx = eng_cmd_idx_reg;
   assign bus.eng_arg     = eng_arg_reg;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb_sd_cmd_arbiter
//  Directed bench for sd_cmd_arbiter: the bench plays both the requesters and
//  the SD engine. Inputs are driven and outputs sampled 1 ns after posedge.
module tb_sd_cmd_arbiter;
   import sd_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sd_cmd_arbiter_if #(.NUM_REQ(3)) bus ();

   sd_cmd_arbiter #(
      .NUM_REQ     (3),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int max_cyc, output int n, output bit seen);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < max_cyc) begin
         tick();
         n++;
         seen = bus.eng_start;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b want 000", bus.grant); end
      checks++; if (bus.ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", bus.ack); end
      checks++; if (bus.eng_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.eng_start); end
      checks++; if (bus.rsp_r1 !== 8'hFF) begin errors++; $display("FAIL reset_r1 got %h want ff", bus.rsp_r1); end
      checks++; if (bus.rsp_err !== OK) begin errors++; $display("FAIL reset_err got %0d want 0", bus.rsp_err); end
      checks++; if (bus.eng_cmd_idx !== 6'd0 || bus.eng_arg !== 32'd0) begin errors++; $display("FAIL reset_cmd got %0d/%h want 0/0", bus.eng_cmd_idx, bus.eng_arg); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_read_sdhc();
      int n; bit seen;
      bus.card_ccs          = 1'b1;
      bus.req_write[0]      = 1'b0;
      bus.req_sector[31:0]  = 32'h0000_1234;
      bus.req               = 3'b001;
      wait_start(20, n, seen);
      checks++; if (n !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", n); end
      checks++; if (bus.eng_cmd_idx !== 6'd17) begin errors++; $display("FAIL rd_idx got %0d want 17", bus.eng_cmd_idx); end
      checks++; if (bus.eng_arg !== 32'h0000_1234) begin errors++; $display("FAIL rd_arg got %h want 00001234", bus.eng_arg); end
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL rd_grant got %b want 001", bus.grant); end
      bus.eng_r1   = 8'h00;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== 3'b001 || bus.grant !== 3'b001) begin errors++; $display("FAIL rd_ack got ack %b grant %b want 001/001", bus.ack, bus.grant); end
      checks++; if (bus.rsp_err !== OK || bus.rsp_r1 !== 8'h00) begin errors++; $display("FAIL rd_rsp got %0d/%h want 0/00", bus.rsp_err, bus.rsp_r1); end
      $display("txn read req0 cmd=%0d arg=%h err=%0d", bus.eng_cmd_idx, bus.eng_arg, bus.rsp_err);
      bus.req = 3'b000;
      tick();
      checks++; if (bus.ack !== 3'b000 || bus.grant !== 3'b000) begin errors++; $display("FAIL rd_release got ack %b grant %b want 000/000", bus.ack, bus.grant); end
   endtask

   task automatic test_write_sdsc();
      int n; bit seen;
      bus.card_ccs          = 1'b0;
      bus.req_write[1]      = 1'b1;
      bus.req_sector[63:32] = 32'd5;
      bus.req               = 3'b010;
      wait_start(20, n, seen);
      checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", n); end
      checks++; if (bus.eng_cmd_idx !== 6'd24) begin errors++; $display("FAIL wr_idx got %0d want 24", bus.eng_cmd_idx); end
      checks++; if (bus.eng_arg !== 32'h0000_0A00) begin errors++; $display("FAIL wr_arg got %h want 00000a00", bus.eng_arg); end
      checks++; if (bus.grant !== 3'b010) begin errors++; $display("FAIL wr_grant got %b want 010", bus.grant); end
      bus.eng_r1   = 8'h00;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== 3'b010 || bus.rsp_err !== OK) begin errors++; $display("FAIL wr_ack got %b/%0d want 010/0", bus.ack, bus.rsp_err); end
      $display("txn write req1 cmd=%0d arg=%h err=%0d", bus.eng_cmd_idx, bus.eng_arg, bus.rsp_err);
      bus.req = 3'b000;
      tick();
   endtask

   task automatic test_range();
      int n; bit seen; bit got; bit started;
      // largest addressable SDSC sector: byte address 0xFFFF_FE00
      bus.req_sector[63:32] = 32'h007F_FFFF;
      bus.req               = 3'b010;
      wait_start(20, n, seen);
      checks++; if (!seen || bus.eng_arg !== 32'hFFFF_FE00) begin errors++; $display("FAIL rng_edge_arg got %h (start %b) want fffffe00", bus.eng_arg, seen); end
      bus.eng_r1   = 8'h00;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      $display("txn write req1 arg=%h err=%0d", bus.eng_arg, bus.rsp_err);
      bus.req = 3'b000;
      tick();
      // first sector beyond SDSC reach
      bus.req_sector[63:32] = 32'h0080_0000;
      bus.req               = 3'b010;
      n = 0; got = 1'b0; started = 1'b0;
      while (!got && n < 20) begin
         tick();
         n++;
         if (bus.eng_start) started = 1'b1;
         if (|bus.ack) got = 1'b1;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL rng_ack_latency got %0d want 3", n); end
      checks++; if (started !== 1'b0) begin errors++; $display("FAIL rng_no_start got %b want 0", started); end
      checks++; if (bus.ack !== 3'b010) begin errors++; $display("FAIL rng_ack got %b want 010", bus.ack); end
      checks++; if (bus.rsp_err !== RANGE || bus.rsp_r1 !== 8'hFF) begin errors++; $display("FAIL rng_rsp got %0d/%h want 3/ff", bus.rsp_err, bus.rsp_r1); end
      $display("txn range req1 err=%0d r1=%h", bus.rsp_err, bus.rsp_r1);
      bus.req = 3'b000;
      tick();
   endtask

   task automatic test_round_robin();
      int order [4] = '{0, 1, 2, 0};
      logic [2:0] exp;
      int n; bit seen;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      bus.card_ccs   = 1'b1;
      bus.req_write  = 3'b000;
      bus.req_sector = {32'h0000_0302, 32'h0000_0301, 32'h0000_0300};
      bus.req        = 3'b111;
      for (int t = 0; t < 4; t++) begin
         exp = 3'b001 << order[t];
         wait_start(20, n, seen);
         checks++; if (!seen) begin errors++; $display("FAIL rr_start%0d got none want start", t); end
         checks++; if (bus.grant !== exp) begin errors++; $display("FAIL rr_grant%0d got %b want %b", t, bus.grant, exp); end
         checks++; if (bus.eng_arg !== 32'h300 + 32'(order[t])) begin errors++; $display("FAIL rr_arg%0d got %h want %h", t, bus.eng_arg, 32'h300 + 32'(order[t])); end
         bus.eng_r1   = 8'h00;
         bus.eng_done = 1'b1;
         tick();
         bus.eng_done = 1'b0;
         checks++; if (bus.ack !== exp) begin errors++; $display("FAIL rr_ack%0d got %b want %b", t, bus.ack, exp); end
         $display("txn rr req%0d arg=%h ack=%b", order[t], bus.eng_arg, bus.ack);
         tick();
         checks++; if (bus.ack !== 3'b000 || bus.grant !== 3'b000) begin errors++; $display("FAIL rr_once%0d got ack %b grant %b want 000/000", t, bus.ack, bus.grant); end
      end
      bus.req = 3'b000;
      tick();
   endtask

   task automatic test_timeout();
      int n; bit seen; bit got;
      bus.req_sector[95:64] = 32'd7;
      bus.req               = 3'b100;
      wait_start(20, n, seen);
      checks++; if (!seen || bus.grant !== 3'b100) begin errors++; $display("FAIL to_start got start %b grant %b want 1/100", seen, bus.grant); end
      n = 0; got = 1'b0;
      while (!got && n < 300) begin
         tick();
         n++;
         if (|bus.ack) got = 1'b1;
      end
      checks++; if (n !== 100) begin errors++; $display("FAIL to_cycles got %0d want 100", n); end
      checks++; if (bus.ack !== 3'b100) begin errors++; $display("FAIL to_ack got %b want 100", bus.ack); end
      checks++; if (bus.rsp_err !== TIMEOUT || bus.rsp_r1 !== 8'hFF) begin errors++; $display("FAIL to_rsp got %0d/%h want 2/ff", bus.rsp_err, bus.rsp_r1); end
      $display("txn timeout req2 cycles=%0d err=%0d", n, bus.rsp_err);
      bus.req = 3'b000;
      tick();
      bus.eng_r1   = 8'h55;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      tick();
      checks++; if (bus.ack !== 3'b000 || bus.grant !== 3'b000) begin errors++; $display("FAIL to_late_ack got ack %b grant %b want 000/000", bus.ack, bus.grant); end
      checks++; if (bus.rsp_r1 !== 8'hFF || bus.rsp_err !== TIMEOUT) begin errors++; $display("FAIL to_late_rsp got %h/%0d want ff/2", bus.rsp_r1, bus.rsp_err); end
   endtask

   task automatic test_r1_err();
      int n; bit seen;
      bus.req = 3'b001;
      wait_start(20, n, seen);
      bus.eng_r1   = 8'h04;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== 3'b001) begin errors++; $display("FAIL r1_ack got %b want 001", bus.ack); end
      checks++; if (bus.rsp_err !== R1_ERR || bus.rsp_r1 !== 8'h04) begin errors++; $display("FAIL r1_rsp got %0d/%h want 1/04", bus.rsp_err, bus.rsp_r1); end
      $display("txn r1err req0 err=%0d r1=%h", bus.rsp_err, bus.rsp_r1);
      bus.req = 3'b000;
      tick();
   endtask

   task automatic test_card_not_ready();
      int n; bit seen; bit any_grant; bit started;
      bus.card_ready = 1'b0;
      bus.req        = 3'b001;
      any_grant = 1'b0; started = 1'b0;
      repeat (10) begin
         tick();
         if (|bus.grant) any_grant = 1'b1;
         if (bus.eng_start) started = 1'b1;
      end
      checks++; if (any_grant !== 1'b0 || started !== 1'b0) begin errors++; $display("FAIL nr_idle got grant %b start %b want 0/0", any_grant, started); end
      bus.card_ready = 1'b1;
      wait_start(20, n, seen);
      bus.card_ready = 1'b0;
      tick();
      checks++; if (bus.ack !== 3'b001 || bus.rsp_err !== TIMEOUT) begin errors++; $display("FAIL nr_abort got ack %b err %0d want 001/2", bus.ack, bus.rsp_err); end
      $display("txn abort req0 err=%0d", bus.rsp_err);
      bus.card_ready = 1'b1;
      bus.req        = 3'b000;
      tick();
   endtask

   task automatic test_reset_in_wait();
      int n; bit seen;
      bus.req = 3'b010;
      wait_start(20, n, seen);
      checks++; if (!seen || bus.grant !== 3'b010) begin errors++; $display("FAIL rw_pre got start %b grant %b want 1/010", seen, bus.grant); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.grant !== 3'b000 || bus.ack !== 3'b000 || bus.eng_start !== 1'b0) begin errors++; $display("FAIL rw_async got grant %b ack %b start %b want 000/000/0", bus.grant, bus.ack, bus.eng_start); end
      bus.req = 3'b111;
      tick();
      rst_n = 1'b1;
      wait_start(20, n, seen);
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL rw_ptr got %b want 001", bus.grant); end
      bus.eng_r1   = 8'h00;
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      checks++; if (bus.ack !== 3'b001) begin errors++; $display("FAIL rw_ack got %b want 001", bus.ack); end
      $display("txn post-reset req0 ack=%b", bus.ack);
      bus.req = 3'b000;
      tick();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.req        = '0;
      bus.req_write  = '0;
      bus.req_sector = '0;
      bus.card_ready = 1'b1;
      bus.card_ccs   = 1'b1;
      bus.eng_busy   = 1'b0;
      bus.eng_done   = 1'b0;
      bus.eng_r1     = 8'h00;
      test_reset();
      test_read_sdhc();
      test_write_sdsc();
      test_range();
      test_round_robin();
      test_timeout();
      test_r1_err();
      test_card_not_ready();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
